wb_burst_arbiter: RTL and testbench
===================================

# wb_burst_arbiter

Two-master Wishbone B3 arbiter that shares one downstream Wishbone slave port between two streamer channels issuing burst writes or reads. Grants are round-robin and held for the whole cycle, with CYC as the lock, so incrementing or wrapping bursts are never interleaved. A per-grant watchdog aborts a stalled cycle with an error to the owning master. The arbiter sits between the stream-to-Wishbone converters and the memory/bus slave (the burst BFM slave in the bench).

## Interface
- WB_AW, 32, address width
- WB_DW, 32, data width; select width is WB_DW/8
- TIMEOUT, 256, cycles without a slave response before abort; 0 disables the watchdog
- wb_clk_i  in  1  clock; all logic on rising edge
- wb_rst_n_i  in  1  reset, asynchronous assert, active-low; deassertion synchronous to wb_clk_i externally
- mN_adr_i / mN_dat_i / mN_sel_i  in  WB_AW / WB_DW / WB_DW/8  master N (N=0,1) address, write data, byte select
- mN_we_i, mN_cyc_i, mN_stb_i  in  1 each  master N control
- mN_cti_i / mN_bte_i  in  3 / 2  master N cycle type and burst type
- mN_dat_o  out  WB_DW  read data, wired from s_dat_i to both masters
- mN_ack_o, mN_err_o, mN_rty_o  out  1 each  master N responses; non-granted master always sees 0
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o  out  as above  muxed from granted master; master 0 fields when idle
- s_cyc_o, s_stb_o  out  1  downstream control
- s_ack_i, s_err_i, s_rty_i  in  1  downstream responses
- s_dat_i  in  WB_DW  downstream read data
- grant_o  out  2  one-hot owner (bit N = master N); 2'b00 when idle
- timeout_o  out  1  one-cycle pulse when the watchdog aborts

## Operation
- States: IDLE, OWN0, OWN1, ABORT. Register last_owner starts at 1 after reset, so master 0 wins the first tie.
- IDLE: if exactly one mN_cyc_i is high, go to OWNN. If both are high, go to OWN of the master that is not last_owner. With neither high, stay.
- OWNN: s_cyc_o = mN_cyc_i and s_stb_o = mN_stb_i. The fields are mN_*. Responses route only to master N: mN_ack_o = s_ack_i, and likewise err and rty.
- OWNN releases when mN_cyc_i is low at a clock edge. It goes to IDLE and sets last_owner = N. A master that drops CYC after an ack with cti=3'b111 therefore releases in that cycle.
- Grant is never revoked while mN_cyc_i stays high, except by the watchdog.
- Watchdog counter (clog2(TIMEOUT+1) bits, saturating):
  - clears on entry to OWNN and on any s_ack_i, s_err_i or s_rty_i;
  - increments each cycle in OWNN with s_stb_o high and no response;
  - holds when stb is low.
- When the counter reaches TIMEOUT:
  - assert mN_err_o for exactly one cycle, with s_ack_i masked in that cycle;
  - pulse timeout_o;
  - force s_cyc_o and s_stb_o low from the next cycle;
  - enter ABORT.
- ABORT: s_cyc_o=0 and all responses to master N are 0. Wait for mN_cyc_i low, then go to IDLE with last_owner = N.
- If TIMEOUT=0, the counter is absent and ABORT is unreachable.
- A simultaneous slave response and counter==TIMEOUT resolves in favour of the response: forward the ack and do not abort.

## Timing
- Reset values: state IDLE, grant_o=0, s_cyc_o=0, s_stb_o=0, all mN_ack_o/err_o/rty_o=0, timeout_o=0, counter 0, last_owner 1.
- Arbitration latency is 1 cycle. A request sampled in IDLE at edge k gives grant_o and s_cyc_o high after edge k. s_cyc_o is never high in IDLE.
- Responses are combinational pass-through, with 0 added cycles: s_ack_i in cycle t gives mN_ack_o in cycle t.
- Handover costs at least one IDLE cycle between OWN0 and OWN1. Back-to-back requesters alternate with a 1-cycle gap.
- The abort error is registered: asserted in the cycle after the counter reaches TIMEOUT, i.e. at TIMEOUT+1 cycles of unanswered stb.
- Reset mid-burst forces all outputs to reset values immediately, without waiting for a clock edge.

## Test plan
- Single burst: m0 does a 4-beat incrementing write, cti 010,010,010,111, with the slave acking every cycle. Required: grant_o=01 one cycle after m0_cyc_i rises, 4 acks on m0, zero acks on m1, and IDLE after m0_cyc_i drops.
- Tie: both cyc rise in the same cycle after reset. Required: m0 is granted first. Hold m1 high; m1 is granted after m0 releases with exactly one IDLE cycle in between. A repeated tie then goes to m0.
- Mid-burst request: m1 raises cyc during beat 2 of m0's 8-beat burst. Required: all 8 beats complete on m0 with s_adr_o never showing m1 fields; m1 is then granted.
- Watchdog: TIMEOUT=16 and the slave never acks m1's stb. Required: m1_err_o and timeout_o are high for one cycle, 17 cycles after stb; s_cyc_o is low the next cycle; the state holds ABORT until m1_cyc_i drops.
- Response races timeout: s_ack_i arrives in the same cycle the counter hits TIMEOUT. Required: an ack is forwarded, there is no err, and the counter clears.
- Reset mid-burst: drive wb_rst_n_i low during beat 3. Required: s_cyc_o and grant_o are 0 immediately. After release, a new tie grants m0.

Source files
------------

// File: rtl/wb_burst_arbiter_if.sv
// Wishbone B3 bus bundle: one master-to-slave link with burst tags (cti/bte).
// The master modport is the bus initiator's view, the slave modport the target's.
interface wb_burst_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic [DW/8-1:0] sel;
    logic            we;
    logic            cyc;
    logic            stb;
    logic [2:0]      cti;
    logic [1:0]      bte;
    logic            ack;
    logic            err;
    logic            rty;

    modport master (
        output adr, dat_w, sel, we, cyc, stb, cti, bte,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb, cti, bte,
        output dat_r, ack, err, rty
    );
endinterface

// File: rtl/wb_burst_arbiter.sv
// Two-master round-robin Wishbone arbiter; CYC locks the grant for whole bursts,
// and a per-grant watchdog aborts a cycle the slave never answers.
module wb_burst_arbiter #(
    parameter int WB_AW   = 32,
    parameter int WB_DW   = 32,
    parameter int TIMEOUT = 256
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    wb_burst_arbiter_if.slave  m0,
    wb_burst_arbiter_if.slave  m1,
    wb_burst_arbiter_if.master s,
    output logic [1:0]         grant_o,
    output logic               timeout_o
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t            state, state_d;
    logic              owner, owner_d;
    logic              last_owner, last_owner_d;
    logic              abort_q, abort_d;
    logic              busy, held, own_cyc, own_stb, resp, wd_hit;
    logic              route0, route1;
    logic [WB_AW-1:0]  adr_mux;
    logic [WB_DW-1:0]  dat_mux;
    logic [WB_DW/8-1:0] sel_mux;

    assign busy    = (state == OWN0) || (state == OWN1);
    assign held    = (state != IDLE);
    assign own_cyc = owner ? m1.cyc : m0.cyc;
    assign own_stb = owner ? m1.stb : m0.stb;
    assign resp    = s.ack | s.err | s.rty;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state;
        owner_d      = owner;
        last_owner_d = last_owner;
        abort_d      = 1'b0;
        unique case (state)
            IDLE: begin
                if (m0.cyc && (!m1.cyc || last_owner)) begin
                    state_d = OWN0;
                    owner_d = 1'b0;
                end else if (m1.cyc) begin
                    state_d = OWN1;
                    owner_d = 1'b1;
                end
            end
            OWN0, OWN1: begin
                if (!own_cyc) begin
                    state_d      = IDLE;
                    last_owner_d = owner;
                end else if (abort_q) begin
                    state_d = ABORT;
                end else begin
                    abort_d = wd_hit;
                end
            end
            ABORT: begin
                if (!own_cyc) begin
                    state_d      = IDLE;
                    last_owner_d = owner;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            abort_q    <= 1'b0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            last_owner <= last_owner_d;
            abort_q    <= abort_d;
        end
    end

    // A response in the same cycle the limit is reached wins, so the hit needs a silent slave.
    if (TIMEOUT > 0) begin : g_wd
        localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
        logic [CW-1:0] cnt;

        always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
            if (!wb_rst_n_i) begin
                cnt <= '0;
            end else if (!busy || resp) begin
                cnt <= '0;
            end else if (own_stb && (cnt != LIMIT)) begin
                cnt <= cnt + CW'(1);
            end
        end

        assign wd_hit = busy && own_stb && !resp && (cnt == LIMIT);
    end else begin : g_no_wd
        assign wd_hit = 1'b0;
    end

    // Fields follow the owner (also through ABORT); master 0 drives them when idle.
    assign adr_mux = (held && owner) ? m1.adr   : m0.adr;
    assign dat_mux = (held && owner) ? m1.dat_w : m0.dat_w;
    assign sel_mux = (held && owner) ? m1.sel   : m0.sel;

    assign s.adr   = adr_mux;
    assign s.dat_w = dat_mux;
    assign s.sel   = sel_mux;
    assign s.we    = (held && owner) ? m1.we  : m0.we;
    assign s.cti   = (held && owner) ? m1.cti : m0.cti;
    assign s.bte   = (held && owner) ? m1.bte : m0.bte;
    assign s.cyc   = busy && own_cyc;
    assign s.stb   = busy && own_stb;

    assign route0 = busy && !owner;
    assign route1 = busy && owner;

    assign m0.ack   = route0 && s.ack && !abort_q;
    assign m0.err   = route0 && (s.err || abort_q);
    assign m0.rty   = route0 && s.rty && !abort_q;
    assign m1.ack   = route1 && s.ack && !abort_q;
    assign m1.err   = route1 && (s.err || abort_q);
    assign m1.rty   = route1 && s.rty && !abort_q;
    assign m0.dat_r = s.dat_r;
    assign m1.dat_r = s.dat_r;

    assign grant_o   = {held && owner, held && !owner};
    assign timeout_o = abort_q;
endmodule

// File: tb/tb_wb_burst_arbiter.sv
// Self-checking bench for wb_burst_arbiter: vector table, directed burst corner
// cases and a randomized run against a cycle-level reference model.
module tb_wb_burst_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant;
    logic       tout;

    wb_burst_arbiter_if #(.AW(AW), .DW(DW)) m0_bus ();
    wb_burst_arbiter_if #(.AW(AW), .DW(DW)) m1_bus ();
    wb_burst_arbiter_if #(.AW(AW), .DW(DW)) s_bus ();

    wb_burst_arbiter #(.WB_AW(AW), .WB_DW(DW), .TIMEOUT(T)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .m0         (m0_bus),
        .m1         (m1_bus),
        .s          (s_bus),
        .grant_o    (grant),
        .timeout_o  (tout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // {grant, s_cyc, s_stb, ack{m1,m0}, err{m1,m0}, rty{m1,m0}, timeout}
    typedef struct {
        logic        rst_n;
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic        ack;
        logic        err;
        logic        rty;
        logic [10:0] exp;
        string       name;
    } vec_t;

    vec_t tbl [20];

    logic [31:0] adr_v [2];
    logic [31:0] dat_v [2];
    logic [3:0]  sel_v [2];
    logic        we_v  [2];
    logic [2:0]  cti_v [2];
    logic [1:0]  bte_v [2];
    logic [31:0] sdat;

    // reference model state
    int owner;
    int last;
    int unans;
    bit aborting;
    bit err_now;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] ctl_now();
        return {grant, s_bus.cyc, s_bus.stb, m1_bus.ack, m0_bus.ack,
                m1_bus.err, m0_bus.err, m1_bus.rty, m0_bus.rty, tout};
    endfunction

    task automatic drive(input logic r, input logic [1:0] c, input logic [1:0] st,
                         input logic a, input logic e, input logic ry);
        rst_n      = r;
        m0_bus.cyc = c[0];
        m1_bus.cyc = c[1];
        m0_bus.stb = st[0];
        m1_bus.stb = st[1];
        s_bus.ack  = a;
        s_bus.err  = e;
        s_bus.rty  = ry;
    endtask

    task automatic apply_fields();
        m0_bus.adr = adr_v[0]; m0_bus.dat_w = dat_v[0]; m0_bus.sel = sel_v[0];
        m0_bus.we  = we_v[0];  m0_bus.cti   = cti_v[0]; m0_bus.bte = bte_v[0];
        m1_bus.adr = adr_v[1]; m1_bus.dat_w = dat_v[1]; m1_bus.sel = sel_v[1];
        m1_bus.we  = we_v[1];  m1_bus.cti   = cti_v[1]; m1_bus.bte = bte_v[1];
        s_bus.dat_r = sdat;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL global time limit reached");
        $fatal(1);
    end

    initial begin
        for (int m = 0; m < 2; m++) begin
            adr_v[m] = '0; dat_v[m] = '0; sel_v[m] = '0;
            we_v[m]  = 1'b0; cti_v[m] = '0; bte_v[m] = '0;
        end
        sdat = '0;
        apply_fields();
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        #2;
        check("reset outputs", ctl_now(), 11'b0);
        tick();
        tick();

        // ---------------- vector table: single burst, tie and routing ----------------
        tbl[0]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 11'b00_0_0_00_00_00_0, "idle after reset"};
        tbl[1]  = '{1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 11'b00_0_0_00_00_00_0, "m0 request sampled"};
        tbl[2]  = '{1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 11'b01_1_1_01_00_00_0, "burst beat 1"};
        tbl[3]  = '{1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 11'b01_1_1_01_00_00_0, "burst beat 2"};
        tbl[4]  = '{1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 11'b01_1_1_01_00_00_0, "burst beat 3"};
        tbl[5]  = '{1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 11'b01_1_1_01_00_00_0, "burst beat 4"};
        tbl[6]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 11'b01_0_0_00_00_00_0, "m0 release"};
        tbl[7]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 11'b00_0_0_00_00_00_0, "idle after burst"};
        tbl[8]  = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 11'b00_0_0_00_00_00_0, "held in reset"};
        tbl[9]  = '{1'b1, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 11'b00_0_0_00_00_00_0, "tie sampled"};
        tbl[10] = '{1'b1, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 11'b01_1_1_01_00_00_0, "tie goes to m0"};
        tbl[11] = '{1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 11'b01_0_0_00_00_00_0, "m0 drops cyc"};
        tbl[12] = '{1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 11'b00_0_0_00_00_00_0, "handover idle gap"};
        tbl[13] = '{1'b1, 2'b11, 2'b10, 1'b0, 1'b0, 1'b1, 11'b10_1_1_00_00_10_0, "m1 owns rty routed"};
        tbl[14] = '{1'b1, 2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 11'b10_1_1_10_00_00_0, "m1 ack only"};
        tbl[15] = '{1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 11'b10_0_0_00_00_00_0, "m1 drops cyc"};
        tbl[16] = '{1'b1, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 11'b00_0_0_00_00_00_0, "repeat tie sampled"};
        tbl[17] = '{1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 1'b0, 11'b01_1_1_00_01_00_0, "repeat tie m0 err"};
        tbl[18] = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 11'b01_0_0_00_00_00_0, "final release"};
        tbl[19] = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 11'b00_0_0_00_00_00_0, "final idle"};

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rst_n, tbl[i].cyc, tbl[i].stb, tbl[i].ack, tbl[i].err, tbl[i].rty);
            #2;
            check(tbl[i].name, ctl_now(), tbl[i].exp);
            tick();
        end

        // ---------------- mid-burst request: 8 beats stay on m0 ----------------
        m1_bus.adr = 32'hdead_0000;
        m0_bus.adr = 32'h0000_1000;
        drive(1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
        tick();
        for (int b = 0; b < 8; b++) begin
            m0_bus.adr = 32'h0000_1000 + 32'(4 * b);
            m0_bus.cti = (b == 7) ? 3'b111 : 3'b010;
            drive(1'b1, (b >= 1) ? 2'b11 : 2'b01, (b >= 1) ? 2'b11 : 2'b01, 1'b1, 1'b0, 1'b0);
            #2;
            check("mid-burst s_adr", s_bus.adr, 32'h0000_1000 + 32'(4 * b));
            check("mid-burst m0_ack", m0_bus.ack, 1'b1);
            check("mid-burst m1_ack", m1_bus.ack, 1'b0);
            check("mid-burst grant", grant, 2'b01);
            tick();
        end
        drive(1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0);
        #2;
        check("mid-burst release cyc", s_bus.cyc, 1'b0);
        tick();
        #2;
        check("mid-burst gap grant", grant, 2'b00);
        tick();
        #2;
        check("mid-burst m1 grant", grant, 2'b10);
        check("mid-burst m1 adr", s_bus.adr, 32'hdead_0000);
        check("mid-burst m1 cyc", s_bus.cyc, 1'b1);

        // ---------------- watchdog on m1: slave never answers ----------------
        begin
            int k;
            k = 0;
            while (!m1_bus.err && k < 40) begin
                tick();
                #2;
                k++;
            end
            check("watchdog err latency", k, 17);
            check("watchdog timeout pulse", tout, 1'b1);
            check("watchdog cyc during err", s_bus.cyc, 1'b1);
        end
        tick();
        #2;
        check("abort cyc low", s_bus.cyc, 1'b0);
        check("abort err one cycle", m1_bus.err, 1'b0);
        check("abort timeout one cycle", tout, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #2;
            check("abort hold", {grant, s_bus.cyc, s_bus.stb}, 4'b10_0_0);
        end
        tick();
        drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        #2;
        check("abort exit grant", grant, 2'b00);

        // ---------------- ack races the limit on m0 ----------------
        drive(1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 16; i++) begin
            #2;
            if (i == 0) check("race grant", grant, 2'b01);
            tick();
        end
        drive(1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
        #2;
        check("race ack forwarded", m0_bus.ack, 1'b1);
        check("race no err", {m0_bus.err, tout}, 2'b00);
        tick();
        drive(1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
        #2;
        begin
            int k;
            k = 0;
            while (!m0_bus.err && k < 40) begin
                tick();
                #2;
                k++;
            end
            check("race counter cleared", k, 17);
        end
        tick();
        drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        #2;
        check("race exit grant", grant, 2'b00);

        // ---------------- reset during beat 3 ----------------
        drive(1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
        tick();
        for (int b = 0; b < 2; b++) begin
            drive(1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
            #2;
            check("pre-reset beat", {grant, m0_bus.ack}, 3'b01_1);
            tick();
        end
        drive(1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
        #1;
        check("beat 3 active", s_bus.cyc, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async reset outputs", ctl_now(), 11'b0);
        tick();
        drive(1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
        #2;
        check("post-reset tie idle", grant, 2'b00);
        tick();
        #2;
        check("post-reset tie to m0", grant, 2'b01);
        tick();

        // ---------------- randomized run against the reference model ----------------
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        owner = -1; last = 1; unans = 0; aborting = 1'b0; err_now = 1'b0;
        begin
            logic [1:0] cyc_r, stb_r;
            logic       a, e, r;
            int         ack_pct;
            cyc_r = 2'b00;
            stb_r = 2'b00;
            ack_pct = 60;
            for (int n = 0; n < 800; n++) begin
                logic [1:0]  eg, ea, ee, er;
                logic        act, oc, os;
                int          o;
                if (n % 60 == 0) ack_pct = ($urandom_range(0, 1) == 0) ? 0 : 60;
                for (int m = 0; m < 2; m++) begin
                    if (cyc_r[m]) cyc_r[m] = ($urandom_range(0, 99) >= 4);
                    else          cyc_r[m] = ($urandom_range(0, 99) < 20);
                    stb_r[m] = cyc_r[m] && ($urandom_range(0, 99) < 75);
                    adr_v[m] = $urandom;
                    dat_v[m] = $urandom;
                    sel_v[m] = 4'($urandom);
                    we_v[m]  = 1'($urandom);
                    cti_v[m] = 3'($urandom);
                    bte_v[m] = 2'($urandom);
                end
                a = ($urandom_range(0, 99) < ack_pct);
                e = ($urandom_range(0, 99) < 3);
                r = ($urandom_range(0, 99) < 3);
                sdat = $urandom;
                apply_fields();
                drive(1'b1, cyc_r, stb_r, a, e, r);
                #2;

                o   = (owner == 1) ? 1 : 0;
                act = (owner >= 0) && !aborting;
                oc  = cyc_r[o];
                os  = stb_r[o];
                eg  = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
                ea  = 2'b00; ee = 2'b00; er = 2'b00;
                if (act) begin
                    ea[o] = a && !err_now;
                    ee[o] = e || err_now;
                    er[o] = r && !err_now;
                end
                check("rand control", ctl_now(), {eg, act && oc, act && os, ea, ee, er, err_now});
                check("rand s_adr", s_bus.adr, adr_v[o]);
                check("rand s_dat", s_bus.dat_w, dat_v[o]);
                check("rand s_fields", {s_bus.sel, s_bus.we, s_bus.cti, s_bus.bte},
                      {sel_v[o], we_v[o], cti_v[o], bte_v[o]});
                check("rand rdata", {m1_bus.dat_r, m0_bus.dat_r}, {sdat, sdat});

                if (owner < 0) begin
                    if (cyc_r == 2'b11)  owner = (last == 1) ? 0 : 1;
                    else if (cyc_r[0])   owner = 0;
                    else if (cyc_r[1])   owner = 1;
                    unans = 0; aborting = 1'b0; err_now = 1'b0;
                end else if (!oc) begin
                    last = owner; owner = -1; aborting = 1'b0; err_now = 1'b0;
                end else if (err_now) begin
                    err_now = 1'b0; aborting = 1'b1;
                end else if (!aborting) begin
                    if (a || e || r) unans = 0;
                    else if (os) begin
                        unans++;
                        if (unans == T + 1) err_now = 1'b1;
                    end
                end
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
